// File: rtl/mig_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module      : mig_arbiter
// Description : Round-robin arbiter that shares one MIG user-interface
//               command/data port between NUM_REQ requesters. The granted
//               command is registered and held until the MIG accepts it.
//               Read data is steered back to the issuing requester through
//               an in-order ID FIFO.
//
// Ports
//   ui_clk_i, ui_reset_i      : MIG user clock, async active-high reset
//   req_en_i / req_w_en_i     : per-requester command valid / write select
//   req_addr_i/data_i/strb_i  : packed per-requester payload (k at [k*W +: W])
//   req_ready_o               : one-cycle accept pulse to the granted requester
//   rsp_valid_o / rsp_data_o  : one-hot read-data valid, broadcast read data
//   en_o, w_en_o, addr_o,
//   data_o, strb_o            : registered MIG command/write-data outputs
//   ready_i, w_ready_i        : MIG command ready / write-data ready
//   valid_i, data_i           : MIG read data return
//   err_o                     : sticky, read data arrived with nothing pending
//
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
module mig_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_W          = 27,
    parameter int DATA_W          = 128,
    parameter int STRB_W          = DATA_W / 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        ui_clk_i,
    input  logic                        ui_reset_i,
    input  logic [NUM_REQ-1:0]          req_en_i,
    input  logic [NUM_REQ-1:0]          req_w_en_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ*STRB_W-1:0]   req_strb_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        en_o,
    output logic                        w_en_o,
    output logic [ADDR_W-1:0]           addr_o,
    output logic [DATA_W-1:0]           data_o,
    output logic [STRB_W-1:0]           strb_o,
    input  logic                        ready_i,
    input  logic                        w_ready_i,
    input  logic                        valid_i,
    input  logic [DATA_W-1:0]           data_i,
    output logic                        err_o
);

    localparam int c_id_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_fifo_aw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_cnt_w  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [c_cnt_w-1:0]   c_cnt_full  = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_id_w-1:0]    c_last_id   = c_id_w'(NUM_REQ - 1);
    localparam logic [c_fifo_aw-1:0] c_last_slot = c_fifo_aw'(MAX_OUTSTANDING - 1);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_issue = 1'b1;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;

    logic                     r_en;
    logic                     r_w_en;
    logic [ADDR_W-1:0]        r_addr;
    logic [DATA_W-1:0]        r_data;
    logic [STRB_W-1:0]        r_strb;
    logic [c_id_w-1:0]        r_gnt_id;
    logic [c_id_w-1:0]        r_rr_ptr;
    logic                     r_err;

    logic [c_id_w-1:0]        r_id_mem [MAX_OUTSTANDING];
    logic [c_fifo_aw-1:0]     r_wr_ptr;
    logic [c_fifo_aw-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]       r_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                     w_fifo_empty;
    logic                     w_fifo_room;
    logic [NUM_REQ-1:0]       w_eligible;
    logic [c_id_w-1:0]        w_scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0]       w_scan_hit;
    logic                     w_pick_valid;
    logic [c_id_w-1:0]        w_pick_id;
    logic                     w_load;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic [c_id_w-1:0]        w_gnt_inc;
    logic [c_fifo_aw-1:0]     w_wr_nxt;
    logic [c_fifo_aw-1:0]     w_rd_nxt;
    logic [c_id_w-1:0]        w_head;

    assign w_fifo_empty = (r_count == '0);
    // Registered count only: a pop in this cycle frees the slot next cycle.
    assign w_fifo_room  = (r_count < c_cnt_full);

    // Writes never touch the ID FIFO, so only reads are throttled by it.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
        assign w_eligible[k] = req_en_i[k] && (req_w_en_i[k] || w_fifo_room);
    end

    // Scan position i looks at requester (rr_ptr + i) mod NUM_REQ.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_scan
        logic [c_id_w:0] w_sum;
        assign w_sum = {1'b0, r_rr_ptr} + (c_id_w + 1)'(i);
        assign w_scan_idx[i] = (w_sum >= (c_id_w + 1)'(NUM_REQ))
                             ? c_id_w'(w_sum - (c_id_w + 1)'(NUM_REQ))
                             : w_sum[c_id_w-1:0];
        assign w_scan_hit[i] = w_eligible[w_scan_idx[i]];
    end

    // Lowest scan position wins; iterate downwards so it is written last.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_scan_hit[i]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = w_scan_idx[i];
            end
        end
    end

    assign w_load    = (r_state == c_st_idle) && w_pick_valid;
    assign w_accept  = (r_state == c_st_issue) && ready_i && (!r_w_en || w_ready_i);
    assign w_push    = w_accept && !r_w_en;
    assign w_pop     = valid_i && !w_fifo_empty;
    assign w_gnt_inc = (r_gnt_id == c_last_id) ? '0 : r_gnt_id + c_id_w'(1);
    assign w_wr_nxt  = (r_wr_ptr == c_last_slot) ? '0 : r_wr_ptr + c_fifo_aw'(1);
    assign w_rd_nxt  = (r_rd_ptr == c_last_slot) ? '0 : r_rd_ptr + c_fifo_aw'(1);
    assign w_head    = r_id_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
        if (ui_reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_pick_valid) w_state_nxt = c_st_issue;
            c_st_issue: if (w_accept)     w_state_nxt = c_st_idle;
            default:                      w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Command register: loaded in IDLE, frozen through ISSUE
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
        if (ui_reset_i) begin
            r_en     <= 1'b0;
            r_w_en   <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_strb   <= '0;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else if (w_load) begin
            r_en     <= 1'b1;
            r_w_en   <= req_w_en_i[w_pick_id];
            r_addr   <= req_addr_i[int'(w_pick_id) * ADDR_W +: ADDR_W];
            r_data   <= req_data_i[int'(w_pick_id) * DATA_W +: DATA_W];
            r_strb   <= req_strb_i[int'(w_pick_id) * STRB_W +: STRB_W];
            r_gnt_id <= w_pick_id;
        end else if (w_accept) begin
            r_en     <= 1'b0;
            r_rr_ptr <= w_gnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // Read-ID FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge ui_clk_i) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= r_gnt_id;
        end
    end

    always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
        if (ui_reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= w_wr_nxt;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read data with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge ui_clk_i or posedge ui_reset_i) begin
        if (ui_reset_i) begin
            r_err <= 1'b0;
        end else if (valid_i && w_fifo_empty) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
        assign req_ready_o[k] = w_accept && (r_gnt_id == c_id_w'(k));
        assign rsp_valid_o[k] = w_pop && (w_head == c_id_w'(k));
    end

    assign rsp_data_o = data_i;
    assign en_o       = r_en;
    assign w_en_o     = r_w_en;
    assign addr_o     = r_addr;
    assign data_o     = r_data;
    assign strb_o     = r_strb;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: doc/mig_arbiter.md
Name: mig_arbiter

Overview:
- Shares one MIG user-interface command/data port between NUM_REQ requesters, e.g. several APB bridges or a bridge plus a DMA.
- Round-robin arbitration. The granted command is registered and held stable until the MIG accepts it.
- Read responses are routed back to the issuing requester through an in-order ID FIFO.
- Sits in the ui_clk domain, between the requesters' MIG-side ports and the MIG controller.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 27, MIG address width.
- DATA_W, 128, MIG data width.
- STRB_W, DATA_W/8, byte-strobe width.
- MAX_OUTSTANDING, 4, maximum reads in flight (ID FIFO depth, power of two).

Ports:
- ui_clk_i  in  1  MIG user clock; the only clock.
- ui_reset_i  in  1  asynchronous, active-high reset.
- req_en_i  in  NUM_REQ  per-requester command valid.
- req_w_en_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester k at [k*ADDR_W +: ADDR_W].
- req_data_i  in  NUM_REQ*DATA_W  packed write data.
- req_strb_i  in  NUM_REQ*STRB_W  packed write strobes.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid_o  out  NUM_REQ  read data valid, one-hot.
- rsp_data_o  out  DATA_W  read data, broadcast to all requesters.
- en_o  out  1  MIG command valid.
- w_en_o  out  1  MIG write command.
- addr_o  out  ADDR_W  MIG address.
- data_o  out  DATA_W  MIG write data.
- strb_o  out  STRB_W  MIG write strobes.
- ready_i  in  1  MIG command ready.
- w_ready_i  in  1  MIG write-data ready.
- valid_i  in  1  MIG read data valid.
- data_i  in  DATA_W  MIG read data.
- err_o  out  1  sticky: read data arrived with no outstanding read.

Behaviour:
- Reset (async assert, sync release) sets:
  - en_o, w_en_o, addr_o, data_o, strb_o = 0; req_ready_o = 0; err_o = 0.
  - rr_ptr = 0; ID FIFO empty, so rsp_valid_o = 0; state = IDLE.
  - Reset asserted mid-ISSUE drops en_o immediately and discards the held command and all outstanding IDs.
- Requester rule: once req_en_i[k] is high, hold it and the payload stable until req_ready_o[k] pulses.
- Eligibility:
  - Requester k is eligible when req_en_i[k] = 1 and either req_w_en_i[k] = 1, or the ID FIFO count < MAX_OUTSTANDING.
  - A read is never issued while the FIFO is full; writes still proceed.
- FSM IDLE:
  - If any requester is eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register its w_en/addr/data/strb into the outputs, set en_o = 1, store gnt_id, go to ISSUE.
  - If nothing is eligible, stay in IDLE with en_o = 0.
- FSM ISSUE:
  - Outputs are held constant.
  - Accept condition: ready_i && (!w_en_o || w_ready_i).
  - On accept, in the same cycle: req_ready_o[gnt_id] = 1; rr_ptr <= gnt_id+1 (wraps at NUM_REQ); if read, push gnt_id into the ID FIFO.
  - Next cycle: en_o = 0, state = IDLE.
  - Result: one bubble cycle between commands; minimum 2 cycles per command.
- Grant lock: no preemption in ISSUE. A requester dropping req_en_i while in ISSUE violates protocol; the command is still completed.
- Read return:
  - Combinational, 0 latency: rsp_valid_o = valid_i ? onehot(fifo_head) : 0; rsp_data_o = data_i.
  - A FIFO pop occurs on every valid_i while the FIFO is non-empty.
  - MIG returns reads in order, so the head ID is always correct.
- Simultaneous push and pop: allowed; count is unchanged and the pushed entry is still written.
  - When full, a pop frees a slot only from the next cycle, because eligibility is evaluated in IDLE on the registered count.
- valid_i with the FIFO empty: data is dropped, rsp_valid_o = 0, err_o <= 1 and stays set until reset.
- Pointer wrap: FIFO read/write pointers wrap modulo MAX_OUTSTANDING; count is ceil(log2(MAX_OUTSTANDING+1)) bits wide.
- Fairness: with all requesters continuously requesting, grants rotate strictly, 0, 1, ..., NUM_REQ-1, 0.

Test Plan:
- Reset then idle, no req_en_i -> en_o = 0, req_ready_o = 0, rsp_valid_o = 0, err_o = 0 for 20 cycles.
- Req0 write addr 0x100, data 0xA5..A5, strb 0xFFFF; ready_i = 1, w_ready_i = 0 for 3 cycles then 1 -> en_o held 4 cycles with w_en_o = 1 and addr_o = 0x100; req_ready_o[0] pulses in the first cycle w_ready_i = 1; en_o = 0 the next cycle.
- Req0 and req1 both issuing reads continuously, ready_i = 1, valid_i returning 3 cycles after each accept -> grant order 0,1,0,1; returned data tagged 0xD0, 0xD1, ... is delivered on rsp_valid_o as 01, 10, 01, 10.
- ready_i = 1, valid_i held 0, req0 issues 5 reads with MAX_OUTSTANDING = 4 -> exactly 4 accepted; the 5th waits; one valid_i pulse -> 5th is accepted 2 cycles later. A write from req1 during the stall is accepted.
- valid_i pulse with no reads outstanding -> rsp_valid_o = 0, err_o = 1 from the next cycle, and stays 1.
- ui_reset_i asserted during ISSUE with en_o = 1 -> en_o = 0 without waiting for a clock edge; after release FIFO is empty and the next grant starts at requester 0.
